// File: rtl/sid_cmd_pkg.sv
// Shared types and constants for the SID serial command decoder.
package sid_cmd_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DATA = 1'b1
    } state_t;

    localparam int ADDR_MARK_BIT = 7;
    localparam int ADDR_RSVD_MSB = 6;
    localparam int ADDR_RSVD_LSB = 5;
    localparam int SID_ADDR_W    = 5;
    localparam int ENTRY_W       = SID_ADDR_W + 8;
    localparam int ERR_W         = 8;

    // An address byte has the mark bit set, both reserved bits clear and
    // names a register no higher than max_addr.
    function automatic logic is_addr_byte(input logic [7:0] b, input int max_addr);
        return b[ADDR_MARK_BIT] &&
               (b[ADDR_RSVD_MSB:ADDR_RSVD_LSB] == 2'b00) &&
               (int'(b[SID_ADDR_W-1:0]) <= max_addr);
    endfunction

endpackage

// File: rtl/sid_wr_fifo.sv
// Small synchronous FIFO holding decoded register writes until the SID
// bus side takes them. Head entry is read straight from storage.
module sid_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             push_en, pop_en;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop needs data present; a push needs room, or a slot freed by a
    // pop in the same cycle.
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    // Storage and pointers; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_en) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({push_en, pop_en})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sid_cmd_decoder.sv
// Decodes the UART byte stream (address byte, data byte) into SID
// register writes and queues them for the slow SID bus interface.
module sid_cmd_decoder
    import sid_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 12000,
    parameter int FIFO_DEPTH     = 4,
    parameter int MAX_ADDR       = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  received,
    input  logic [7:0]            rx_byte,
    input  logic                  recv_error,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [SID_ADDR_W-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  overflow,
    output logic [ERR_W-1:0]      err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic [SID_ADDR_W-1:0] addr_q, addr_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [ERR_W-1:0]      err_q, err_d;
    logic                  ovf_q, ovf_d;
    logic                  err_inc;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]    fifo_dout;

    assign wr_valid  = !fifo_empty;
    assign pop       = wr_valid && wr_ready;
    assign wr_addr   = fifo_dout[ENTRY_W-1:8];
    assign wr_data   = fifo_dout[7:0];
    assign busy      = (state_q == WAIT_DATA);
    assign overflow  = ovf_q;
    assign err_count = err_q;

    // Next-state logic: recv_error outranks everything, a byte beats a
    // coincident timeout expiry.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tmr_d   = tmr_q;
        err_inc = 1'b0;
        push    = 1'b0;
        if (recv_error) begin
            state_d = IDLE;
            addr_d  = '0;
            err_inc = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (received) begin
                        if (is_addr_byte(rx_byte, MAX_ADDR)) begin
                            addr_d  = rx_byte[SID_ADDR_W-1:0];
                            tmr_d   = '0;
                            state_d = WAIT_DATA;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (received) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else if (tmr_q == TMR_LAST) begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sticky overflow and saturating error counter next values.
    always_comb begin
        ovf_d = ovf_q | (push && fifo_full && !pop);
        err_d = err_q;
        if (err_inc && (err_q != {ERR_W{1'b1}})) err_d = err_q + ERR_W'(1);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tmr_q   <= '0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    sid_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({addr_q, rx_byte}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (fifo_dout)
    );

endmodule

// File: tb/tb_sid_cmd_decoder.sv
// Directed bench for sid_cmd_decoder: a per-cycle vector table plus
// hand-written sequences for timeout, overflow, error and reset cases.
module tb_sid_cmd_decoder;

    localparam int TO = 50;

    logic       clk, rst, received, recv_error, wr_ready;
    logic [7:0] rx_byte;
    logic       wr_valid, busy, overflow;
    logic [4:0] wr_addr;
    logic [7:0] wr_data, err_count;

    int n_chk = 0;
    int n_err = 0;
    int hs_cnt = 0;

    sid_cmd_decoder #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4), .MAX_ADDR(24)) dut (
        .clk(clk), .rst(rst), .received(received), .rx_byte(rx_byte),
        .recv_error(recv_error), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .overflow(overflow), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completed handshakes.
    always @(posedge clk) if (!rst && wr_valid && wr_ready) hs_cnt <= hs_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1);
    end

    typedef struct {
        logic       rcv;
        logic       rerr;
        logic [7:0] b;
        logic       rdy;
        logic       ev;
        logic [4:0] ea;
        logic [7:0] ed;
        logic       eb;
        logic [7:0] ee;
    } vec_t;

    vec_t tv [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: inputs held across the edge, outputs settle 1 time unit after.
    task automatic step(input logic rcv, input logic rerr, input logic [7:0] b, input logic rdy);
        received   = rcv;
        recv_error = rerr;
        rx_byte    = b;
        wr_ready   = rdy;
        @(posedge clk);
        #1;
        received   = 1'b0;
        recv_error = 1'b0;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid"}, wr_valid, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".ovf"}, overflow, 0);
        chk({tag, ".err"}, err_count, 0);
        chk({tag, ".addr"}, wr_addr, 0);
        chk({tag, ".data"}, wr_data, 0);
    endtask

    initial begin
        rst = 1'b1; received = 1'b0; recv_error = 1'b0; rx_byte = 8'h00; wr_ready = 1'b0;
        //          rcv rerr byte    rdy  ev  ea     ed     eb  ee
        tv[0]  = '{1'b1, 1'b0, 8'h84, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 8'd0};
        tv[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 8'd0};
        tv[2]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 5'h04, 8'h5A, 1'b0, 8'd0};
        tv[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 8'd0};
        tv[4]  = '{1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 8'd1};
        tv[5]  = '{1'b1, 1'b0, 8'h20, 1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 8'd2};
        tv[6]  = '{1'b1, 1'b0, 8'hC1, 1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 8'd3};
        tv[7]  = '{1'b1, 1'b0, 8'h98, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 8'd3};
        tv[8]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 5'h18, 8'hFF, 1'b0, 8'd3};
        tv[9]  = '{1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 5'h00, 8'h00, 1'b1, 8'd3};
        tv[10] = '{1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 5'h00, 8'h80, 1'b0, 8'd3};
        tv[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 8'd3};
        tv[12] = '{1'b1, 1'b1, 8'h85, 1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 8'd4};

        idle(2, 1'b0);
        rst = 1'b0;
        chk_reset_state("reset");

        // Vector table: basic pair, rejected bytes, address/data boundaries.
        for (int i = 0; i < 13; i++) begin
            step(tv[i].rcv, tv[i].rerr, tv[i].b, tv[i].rdy);
            chk($sformatf("tv%0d.valid", i), wr_valid, tv[i].ev);
            chk($sformatf("tv%0d.busy", i), busy, tv[i].eb);
            chk($sformatf("tv%0d.err", i), err_count, tv[i].ee);
            if (tv[i].ev) begin
                chk($sformatf("tv%0d.addr", i), wr_addr, tv[i].ea);
                chk($sformatf("tv%0d.data", i), wr_data, tv[i].ed);
            end
            if (i == 3) chk("first_pair_handshakes", hs_cnt, 1);
        end
        chk("table_handshakes", hs_cnt, 3);
        chk("table_ovf", overflow, 0);

        // Long gap: timeout, then the late byte is rejected as an address.
        do_reset();
        step(1'b1, 1'b0, 8'h81, 1'b1);
        idle(TO + 4, 1'b1);
        chk("to.busy", busy, 0);
        chk("to.err", err_count, 1);
        step(1'b1, 1'b0, 8'h10, 1'b1);
        chk("to.late_err", err_count, 2);
        chk("to.valid", wr_valid, 0);

        // Expiry boundary: still waiting after TO-1 idle cycles, expired one later.
        do_reset();
        step(1'b1, 1'b0, 8'h83, 1'b1);
        idle(TO - 1, 1'b1);
        chk("tob.busy_before", busy, 1);
        idle(1, 1'b1);
        chk("tob.busy_after", busy, 0);
        chk("tob.err", err_count, 1);
        // Byte on the expiry cycle wins.
        step(1'b1, 1'b0, 8'h83, 1'b0);
        idle(TO - 1, 1'b0);
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        chk("tow.valid", wr_valid, 1);
        chk("tow.addr", wr_addr, 5'h03);
        chk("tow.data", wr_data, 8'hA5);
        chk("tow.err", err_count, 1);

        // recv_error mid-pair discards the address; next byte fails as address.
        do_reset();
        step(1'b1, 1'b0, 8'h85, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("rerr.busy", busy, 0);
        chk("rerr.err", err_count, 1);
        step(1'b1, 1'b0, 8'h33, 1'b1);
        chk("rerr.err2", err_count, 2);
        chk("rerr.valid", wr_valid, 0);
        chk("rerr.hs", hs_cnt, 3);

        // Overflow: six pairs into a four-deep FIFO with no drain.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'h80 | 8'(i), 1'b0);
            step(1'b1, 1'b0, 8'(i), 1'b0);
        end
        chk("ovf.flag", overflow, 1);
        chk("ovf.err", err_count, 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf.valid%0d", i), wr_valid, 1);
            chk($sformatf("ovf.addr%0d", i), wr_addr, 5'(i));
            chk($sformatf("ovf.data%0d", i), wr_data, 8'(i));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("ovf.drained", wr_valid, 0);
        chk("ovf.sticky", overflow, 1);

        // Push and pop together while full: no drop, order preserved.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 8'h81 + 8'(i), 1'b0);
            step(1'b1, 1'b0, 8'h11 * 8'(i + 1), 1'b0);
        end
        step(1'b1, 1'b0, 8'h85, 1'b0);
        step(1'b1, 1'b0, 8'h55, 1'b1);
        chk("fpp.ovf", overflow, 0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("fpp.addr%0d", i), wr_addr, 5'(i + 1));
            chk($sformatf("fpp.data%0d", i), wr_data, 8'h11 * 8'(i + 1));
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end
        chk("fpp.drained", wr_valid, 0);

        // Reset on the data byte's pulse drops the pending pair.
        do_reset();
        step(1'b1, 1'b0, 8'h82, 1'b0);
        chk("rmp.busy", busy, 1);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h77, 1'b1);
        rst = 1'b0;
        chk_reset_state("rmp");
        idle(3, 1'b1);
        chk("rmp.valid_later", wr_valid, 0);
        chk("rmp.busy_later", busy, 0);

        // Error counter saturates at 255.
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
        chk("sat.err", err_count, 255);
        chk("sat.busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sid_cmd_decoder.md
Name: sid_cmd_decoder

Overview:
- Sits directly downstream of the UART receiver in the sid8580 design and consumes its received / rx_byte / recv_error outputs.
- Decodes a two-byte serial command stream (address byte, then data byte) into SID register writes.
- Buffers decoded writes in a small FIFO and presents them to the SID bus interface over a valid/ready handshake, so writes survive the SID's slow phi2-gated write acceptance.

Parameters:
- TIMEOUT_CYCLES, 12000, clk cycles allowed between an address byte and its data byte (1 ms at 12 MHz); minimum 2.
- FIFO_DEPTH, 4, write FIFO entries; power of two, minimum 2.
- MAX_ADDR, 24, highest writable SID register (0x18); addresses above it are rejected.

Ports:
- clk  in  1  master clock.
- rst  in  1  synchronous reset, active-high.
- received  in  1  one-cycle pulse: rx_byte holds a new byte.
- rx_byte  in  8  byte from the UART receiver; sampled only when received=1.
- recv_error  in  1  one-cycle pulse: UART framing/start error.
- wr_valid  out  1  FIFO head holds a pending register write.
- wr_ready  in  1  SID bus accepts the head entry this cycle.
- wr_addr  out  5  register address of the head entry.
- wr_data  out  8  data of the head entry.
- busy  out  1  address accepted, data byte outstanding.
- overflow  out  1  sticky: a decoded write was dropped because the FIFO was full.
- err_count  out  8  saturating count of protocol errors.

Behaviour:
- Reset (clk edge with rst=1):
  - State returns to IDLE and the FIFO is emptied.
  - wr_valid=0, busy=0, overflow=0, err_count=0.
  - wr_addr and wr_data read 0.
  - Reset mid-pair discards the pending address.
- Address byte format: bit7=1, bits6:5=00, bits4:0=register address.
- State IDLE:
  - received with a valid address byte (format correct and addr<=MAX_ADDR): latch addr, clear the timeout counter, go to WAIT_DATA.
  - received with any other byte: stay in IDLE, err_count+1.
- State WAIT_DATA (busy=1):
  - received: the byte is data regardless of its bit7; push {addr,data} into the FIFO, go to IDLE.
  - Timeout counter increments every cycle. On reaching TIMEOUT_CYCLES-1 with no byte received: go to IDLE, err_count+1, nothing pushed.
  - A byte received in the same cycle as expiry wins: the push happens and no error is counted.
- recv_error in any state: go to IDLE, discard the latched address, err_count+1.
  - recv_error outranks a coincident received; the byte is ignored.
- Latency: the push happens on the edge where received=1. wr_valid is high the following cycle when the FIFO was empty.
- FIFO:
  - Entries are 13 bits ({addr,data}), first-in first-out.
  - wr_addr/wr_data are driven from the head and are stable while wr_valid=1 and wr_ready=0.
  - Pop occurs when wr_valid and wr_ready are both 1.
  - Push while full without a simultaneous pop: entry dropped, overflow set to 1 (cleared only by rst). The error is not added to err_count.
  - Push and pop in the same cycle while full: both happen and occupancy is unchanged.
  - Push and pop in the same cycle while empty: the push only lands; wr_valid=0 that cycle, so no pop.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.
- err_count saturates at 255 and never wraps.
- Timeout counter width is clog2(TIMEOUT_CYCLES).
- All outputs are registered or driven from registered FIFO storage. There is no combinational path from received to wr_valid.

Decomposition:
- Package sid_cmd_pkg:
  - State encoding: IDLE, WAIT_DATA.
  - Constants: ADDR_MARK_BIT=7, ADDR_RSVD_MSB=6, ADDR_RSVD_LSB=5, SID_ADDR_W=5, entry width 13.
- Sub-module sid_wr_fifo: parameterised depth/width synchronous FIFO with push, pop, full, empty, head data.
- The decoder FSM, timeout counter and error counter stay in sid_cmd_decoder.

Test Plan:
- Bytes 0x84 then 0x5A, wr_ready=1: exactly one handshake with wr_addr=0x04, wr_data=0x5A; busy high between the bytes; err_count=0.
- 0x99 (addr 25 > MAX_ADDR), then 0x20 (bit7=0), then 0xC1 (reserved bits set): no writes, err_count=3, busy stays 0.
- 0x81, then 0x10 arriving TIMEOUT_CYCLES+5 cycles later: no write, err_count=1; 0x10 is then rejected in IDLE, so err_count=2.
- 0x85, then recv_error, then 0x33: no write, err_count=2 (recv_error plus 0x33 rejected as an address).
- wr_ready=0, six pairs 0x80..0x85 with data 0x00..0x05: first four are retained, overflow=1. With wr_ready=1 afterwards, handshakes occur in order addr 0..3, data 0..3.
- 0x82 and data 0x77 sent, rst asserted one cycle during the data byte's received pulse: all outputs return to reset values and no write appears.
